// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the matching receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 104;
  localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..term and pulses tick on the terminal count, then wraps.
module uart_baud_counter #(
  parameter int PERIOD_MAX = 104,
  parameter int W          = $clog2(PERIOD_MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] term,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = (cnt == term);

  // Wrapping on tick restarts the count at 0 on every state change.
  always_ff @(posedge clk) begin
    if (rst || clear || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per en pulse while idle, busy held across the whole frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] data,
  output logic       busy,
  output logic       txd
);

  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CW        = $clog2(STOP_CLKS);
  localparam logic [CW-1:0] BIT_TERM  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_TERM = CW'(STOP_CLKS - 1);

  uart_state_e               state;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [2:0]                bit_idx;
  logic                      tick;
  logic                      clear;
  logic [CW-1:0]             term;

  assign clear = (state == IDLE);
  assign term  = (state == STOP) ? STOP_TERM : BIT_TERM;

  uart_baud_counter #(.PERIOD_MAX(STOP_CLKS)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .term (term),
    .tick (tick)
  );

  // txd is registered, so each transition loads the level of the bit about to start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en) begin
          shreg   <= data;
          bit_idx <= '0;
          state   <= START;
          txd     <= 1'b0;
          busy    <= 1'b1;
        end
        START: if (tick) begin
          state <= DATA;
          txd   <= shreg[0];
        end
        DATA: if (tick) begin
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
            state <= STOP;
            txd   <= 1'b1;
          end else begin
            shreg   <= shreg >> 1;
            txd     <= shreg[1];
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: if (tick) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table-driven frames, directed corner cases, reference receiver with scoreboard.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en1 = 1'b0, en2 = 1'b0;
  logic [7:0] data1 = '0, data2 = '0;
  logic       busy1, busy2, txd1, txd2;

  int n_checks = 0;
  int n_fail   = 0;
  int frames1  = 0, frames2 = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .data(data1), .busy(busy1), .txd(txd1));
  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .data(data2), .busy(busy2), .txd(txd2));

  typedef struct {
    logic [7:0] data;
    bit         glitch;     // pulse en with 0xFF mid-frame
    logic [9:0] line;       // expected line levels in time order, bit 0 = start
    int         busy_len;
    int         stop_len;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_txd(input int w);
    return (w == 1) ? txd1 : txd2;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 1) ? busy1 : busy2;
  endfunction

  task automatic drive(input int w, input logic e, input logic [7:0] d);
    if (w == 1) begin en1 = e; data1 = d; end
    else        begin en2 = e; data2 = d; end
  endtask

  // Called at a negedge with the DUT idle; returns at the first negedge with busy low.
  task automatic send_frame(input int w, input vec_t v, input string tag);
    int j, busy_n, stop_n, off, idx;
    logic t;
    drive(w, 1'b1, v.data);
    if (w == 1) q1.push_back(v.data); else q2.push_back(v.data);
    @(negedge clk);
    drive(w, 1'b0, ~v.data);
    j = 1; busy_n = 0; stop_n = 0;
    while (get_busy(w) === 1'b1 && j < 200) begin
      busy_n++;
      off = j - 1;
      idx = off / CPB;
      t   = get_txd(w);
      if (idx >= 9 && t === 1'b1) stop_n++;
      if (off % CPB == CPB / 2 && idx < 10) chk({tag, "_line"}, t, v.line[idx]);
      if (v.glitch && j == 15) drive(w, 1'b1, 8'hFF);
      else if (v.glitch && j == 16) drive(w, 1'b0, 8'hFF);
      j++;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, busy_n, v.busy_len);
    chk({tag, "_stop_len"}, stop_n, v.stop_len);
  endtask

  // Reference receiver: samples mid-bit, abandons the frame if rst is seen.
  task automatic rx_loop(input int w);
    logic [7:0] b;
    logic       t;
    bit         aborted;
    int         n;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || get_txd(w) !== 1'b0) continue;
      aborted = 0;
      b = '0;
      for (int k = 0; k < 10 && !aborted; k++) begin
        n = (k == 0) ? CPB / 2 : CPB;
        repeat (n) begin
          @(negedge clk);
          if (rst !== 1'b0) aborted = 1;
        end
        if (!aborted) begin
          t = get_txd(w);
          if (k == 0)      chk("rx_start", t, 1'b0);
          else if (k < 9)  b[k-1] = t;
          else             chk("rx_stop", t, 1'b1);
        end
      end
      if (!aborted) begin
        if (w == 1) begin
          frames1++;
          if (q1.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rx1_unexpected_frame: got %0h expected none", b);
          end else chk("rx1_byte", b, q1.pop_front());
        end else begin
          frames2++;
          if (q2.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rx2_unexpected_frame: got %0h expected none", b);
          end else chk("rx2_byte", b, q2.pop_front());
        end
      end
    end
  endtask

  initial rx_loop(1);
  initial rx_loop(2);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[3];
    vec_t v;
    int   idle_busy;

    vecs[0] = '{data: 8'h55, glitch: 1'b0, line: 10'b1_01010101_0, busy_len: 40, stop_len: 4};
    vecs[1] = '{data: 8'hA3, glitch: 1'b1, line: 10'b1_10100011_0, busy_len: 40, stop_len: 4};
    vecs[2] = '{data: 8'h3C, glitch: 1'b0, line: 10'b1_00111100_0, busy_len: 40, stop_len: 4};

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_txd", txd1, 1'b1);
      chk("rst_busy", busy1, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_txd", txd1, 1'b1);
    chk("post_rst_busy", busy1, 1'b0);
    chk("post_rst_txd2", txd2, 1'b1);

    foreach (vecs[i]) begin
      send_frame(1, vecs[i], $sformatf("vec%0d", i));
      idle_busy = 0;
      repeat (8) begin
        @(negedge clk);
        if (busy1 !== 1'b0 || txd1 !== 1'b1) idle_busy++;
      end
      chk($sformatf("vec%0d_idle_after", i), idle_busy, 0);
    end

    // Back-to-back: second en on the first busy-low cycle
    v = '{data: 8'h00, glitch: 1'b0, line: 10'b1_00000000_0, busy_len: 40, stop_len: 4};
    send_frame(1, v, "b2b_a");
    chk("b2b_gap_txd", txd1, 1'b1);
    chk("b2b_gap_busy", busy1, 1'b0);
    v = '{data: 8'hFF, glitch: 1'b0, line: 10'b1_11111111_0, busy_len: 40, stop_len: 4};
    send_frame(1, v, "b2b_b");
    repeat (3) @(negedge clk);

    // Reset during data bit 3 of 0x0F (no scoreboard entry: frame is aborted)
    drive(1, 1'b1, 8'h0F);
    @(negedge clk);
    drive(1, 1'b0, 8'h00);
    repeat (17) @(negedge clk);
    chk("abort_pre_busy", busy1, 1'b1);
    chk("abort_pre_txd", txd1, 1'b1);
    rst = 1'b1;
    drive(1, 1'b1, 8'h77);     // en together with rst must be dropped
    @(negedge clk);
    chk("abort_txd", txd1, 1'b1);
    chk("abort_busy", busy1, 1'b0);
    drive(1, 1'b0, 8'h00);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_stays_idle", busy1, 1'b0);
    end
    v = '{data: 8'h81, glitch: 1'b0, line: 10'b1_10000001_0, busy_len: 40, stop_len: 4};
    send_frame(1, v, "post_abort");

    // Two stop bits on the second instance
    v = '{data: 8'hC3, glitch: 1'b0, line: 10'b1_11000011_0, busy_len: 44, stop_len: 8};
    send_frame(2, v, "stop2");

    repeat (10) @(negedge clk);
    chk("sb1_empty", q1.size(), 0);
    chk("sb2_empty", q2.size(), 0);
    chk("rx1_frames", frames1, 6);
    chk("rx2_frames", frames2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
